// File: rtl/hazard_ctrl_param_if.sv
// Hazard controller bundle: pipeline status in, latch enables/flushes out.
// master = datapath side, slave = hazard controller.
interface hazard_ctrl_param_if #(
   parameter int REG_W = 5,
   parameter int CNT_W = 32
);
   logic             ihit;
   logic             dhit;
   logic             dmem_req_mem;
   logic             load_ex;
   logic [REG_W-1:0] rd_ex;
   logic [REG_W-1:0] rs_id;
   logic [REG_W-1:0] rt_id;
   logic             uses_rt_id;
   logic             jump_id;
   logic             br_taken_mem;
   logic             halt_wb;
   logic             enable_IF_ID;
   logic             enable_ID_EX;
   logic             enable_EX_MEM;
   logic             enable_MEM_WB;
   logic             flush_IF_ID;
   logic             flush_ID_EX;
   logic             flush_EX_MEM;
   logic             flush_MEM_WB;
   logic             pc_en;
   logic             halted;
   logic [CNT_W-1:0] stall_cycles;

   modport master (
      output ihit, dhit, dmem_req_mem, load_ex,
      output rd_ex, rs_id, rt_id, uses_rt_id,
      output jump_id, br_taken_mem, halt_wb,
      input  enable_IF_ID, enable_ID_EX,
      input  enable_EX_MEM, enable_MEM_WB,
      input  flush_IF_ID, flush_ID_EX,
      input  flush_EX_MEM, flush_MEM_WB,
      input  pc_en, halted, stall_cycles
   );

   modport slave (
      input  ihit, dhit, dmem_req_mem, load_ex,
      input  rd_ex, rs_id, rt_id, uses_rt_id,
      input  jump_id, br_taken_mem, halt_wb,
      output enable_IF_ID, enable_ID_EX,
      output enable_EX_MEM, enable_MEM_WB,
      output flush_IF_ID, flush_ID_EX,
      output flush_EX_MEM, flush_MEM_WB,
      output pc_en, halted, stall_cycles
   );
endinterface

// File: rtl/hazard_ctrl_param.sv
// 5-stage pipeline hazard controller: load-use bubbles, branch/jump
// flushes, dmem wait freeze, sticky halt, saturating stall counter.
module hazard_ctrl_param #(
   parameter int REG_W      = 5,
   parameter int LU_BUBBLES = 1,
   parameter int CNT_W      = 32
) (
   input logic                CLK,
   input logic                nRST,
   hazard_ctrl_param_if.slave hz
);
   typedef enum logic {RUN, BUBBLE} state_t;

   state_t           state;
   logic [1:0]       bcnt;
   logic             halted_q;
   logic [CNT_W-1:0] stall_q;

   logic [REG_W-1:0] rd;
   logic mem_wait, adv, lu_haz;
   logic en_if, en_id, en_ex, en_wb;
   logic fl_if, fl_id, fl_ex, fl_wb;
   logic pc;

   assign rd       = hz.rd_ex;
   assign mem_wait = hz.dmem_req_mem & ~hz.dhit;
   assign adv      = hz.ihit & ~mem_wait;
   assign lu_haz   = hz.load_ex && (rd != '0) &&
                     ((rd == hz.rs_id) ||
                      (hz.uses_rt_id && (rd == hz.rt_id)));

   always_comb begin
      en_if = 1'b0;
      en_id = 1'b0;
      en_ex = 1'b0;
      en_wb = 1'b0;
      fl_if = 1'b0;
      fl_id = 1'b0;
      fl_ex = 1'b0;
      fl_wb = 1'b0;
      pc    = 1'b0;
      if (nRST && !halted_q && !mem_wait) begin
         if (!adv) begin
            // let a completed memory op retire without re-issuing it
            en_ex = hz.dhit;
            en_wb = hz.dhit;
            fl_ex = hz.dhit;
         end else if (hz.br_taken_mem) begin
            en_if = 1'b1;
            en_id = 1'b1;
            en_ex = 1'b1;
            en_wb = 1'b1;
            pc    = 1'b1;
            fl_if = 1'b1;
            fl_id = 1'b1;
            fl_ex = 1'b1;
         end else if (state == BUBBLE || lu_haz) begin
            en_id = 1'b1;
            fl_id = 1'b1;
            en_ex = 1'b1;
            en_wb = 1'b1;
         end else begin
            en_if = 1'b1;
            en_id = 1'b1;
            en_ex = 1'b1;
            en_wb = 1'b1;
            pc    = 1'b1;
            fl_if = hz.jump_id;
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state    <= RUN;
         bcnt     <= '0;
         halted_q <= 1'b0;
         stall_q  <= '0;
      end else if (!halted_q) begin
         if (!pc && stall_q != '1)
            stall_q <= stall_q + 1'b1;
         if (adv) begin
            if (hz.halt_wb)
               halted_q <= 1'b1;
            if (hz.br_taken_mem) begin
               state <= RUN;
               bcnt  <= '0;
            end else if (state == BUBBLE) begin
               if (bcnt == 2'd1)
                  state <= RUN;
               bcnt <= bcnt - 2'd1;
            end else if (lu_haz && LU_BUBBLES > 1) begin
               state <= BUBBLE;
               bcnt  <= 2'(LU_BUBBLES - 1);
            end
         end
      end
   end

   assign hz.enable_IF_ID  = en_if;
   assign hz.enable_ID_EX  = en_id;
   assign hz.enable_EX_MEM = en_ex;
   assign hz.enable_MEM_WB = en_wb;
   assign hz.flush_IF_ID   = fl_if;
   assign hz.flush_ID_EX   = fl_id;
   assign hz.flush_EX_MEM  = fl_ex;
   assign hz.flush_MEM_WB  = fl_wb;
   assign hz.pc_en         = pc;
   assign hz.halted        = halted_q;
   assign hz.stall_cycles  = stall_q;
endmodule

// File: tb/tb_hazard_ctrl_param.sv
// Bench for hazard_ctrl_param: directed scenarios plus random traffic
// checked against a remaining-bubble-count reference model.
module tb_hazard_ctrl_param;
   localparam int RW   = 5;
   localparam int LU   = 2;
   localparam int CW   = 4;
   localparam int MAXC = (1 << CW) - 1;

   localparam logic [8:0] V_RUN  = 9'b1_1111_0000;
   localparam logic [8:0] V_LU   = 9'b0_0111_0100;
   localparam logic [8:0] V_BR   = 9'b1_1111_1110;
   localparam logic [8:0] V_JMP  = 9'b1_1111_1000;
   localparam logic [8:0] V_OFF  = 9'b0_0000_0000;
   localparam logic [8:0] V_RET  = 9'b0_0011_0010;

   logic CLK;
   logic nRST;
   int   total = 0;
   int   bad   = 0;

   int   m_left;
   bit   m_halt;
   int   m_stall;

   hazard_ctrl_param_if #(.REG_W(RW), .CNT_W(CW)) hz ();

   hazard_ctrl_param #(
      .REG_W(RW), .LU_BUBBLES(LU), .CNT_W(CW)
   ) dut (
      .CLK (CLK),
      .nRST(nRST),
      .hz  (hz.slave)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // {pc_en, en IF/ID/EX/WB, flush IF/ID/EX/WB}
   function automatic logic [8:0] got_vec();
      return {hz.pc_en,
              hz.enable_IF_ID, hz.enable_ID_EX,
              hz.enable_EX_MEM, hz.enable_MEM_WB,
              hz.flush_IF_ID, hz.flush_ID_EX,
              hz.flush_EX_MEM, hz.flush_MEM_WB};
   endfunction

   function automatic bit m_lu();
      int rd, rs, rt;
      rd = int'(hz.rd_ex);
      rs = int'(hz.rs_id);
      rt = int'(hz.rt_id);
      if (!hz.load_ex || rd == 0) return 1'b0;
      return (rd == rs) || (hz.uses_rt_id && rd == rt);
   endfunction

   function automatic bit m_adv();
      return hz.ihit && !(hz.dmem_req_mem && !hz.dhit);
   endfunction

   function automatic logic [8:0] model_out();
      if (!nRST || m_halt) return V_OFF;
      if (hz.dmem_req_mem && !hz.dhit) return V_OFF;
      if (!hz.ihit) return hz.dhit ? V_RET : V_OFF;
      if (hz.br_taken_mem) return V_BR;
      if (m_left > 0 || m_lu()) return V_LU;
      if (hz.jump_id) return V_JMP;
      return V_RUN;
   endfunction

   task automatic model_reset();
      m_left  = 0;
      m_halt  = 1'b0;
      m_stall = 0;
   endtask

   task automatic model_step();
      logic [8:0] e;
      e = model_out();
      if (!nRST) begin
         model_reset();
         return;
      end
      if (m_halt) return;
      if (!e[8] && m_stall < MAXC) m_stall++;
      if (m_adv()) begin
         if (hz.halt_wb) m_halt = 1'b1;
         if (hz.br_taken_mem) m_left = 0;
         else if (m_left > 0) m_left--;
         else if (m_lu()) m_left = LU - 1;
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge CLK);
      #1;
   endtask

   task automatic clr_inputs();
      hz.ihit         = 1'b1;
      hz.dhit         = 1'b0;
      hz.dmem_req_mem = 1'b0;
      hz.load_ex      = 1'b0;
      hz.rd_ex        = '0;
      hz.rs_id        = '0;
      hz.rt_id        = '0;
      hz.uses_rt_id   = 1'b0;
      hz.jump_id      = 1'b0;
      hz.br_taken_mem = 1'b0;
      hz.halt_wb      = 1'b0;
   endtask

   task automatic do_reset();
      clr_inputs();
      nRST = 1'b0;
      model_reset();
      @(negedge CLK);
      nRST = 1'b1;
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      clr_inputs();
      nRST = 1'b0;
      model_reset();
      #1;
      total++;
      if (got_vec() !== V_OFF) begin
         $display("FAIL reset_outs got=%b exp=%b", got_vec(), V_OFF);
         bad++;
      end
      total++;
      if (hz.halted !== 1'b0 || hz.stall_cycles !== '0) begin
         $display("FAIL reset_regs got=%b/%0d exp=0/0",
                  hz.halted, hz.stall_cycles);
         bad++;
      end
      @(negedge CLK);
      nRST = 1'b1;
      @(posedge CLK);
      #1;
   endtask

   task automatic test_run();
      clr_inputs();
      @(negedge CLK);
      total++;
      if (got_vec() !== V_RUN || hz.stall_cycles !== '0) begin
         $display("FAIL run got=%b/%0d exp=%b/0",
                  got_vec(), hz.stall_cycles, V_RUN);
         bad++;
      end
      tick();
   endtask

   task automatic test_load_use();
      do_reset();
      hz.load_ex = 1'b1;
      hz.rd_ex   = 5'd8;
      hz.rs_id   = 5'd8;
      for (int i = 0; i < 2; i++) begin
         @(negedge CLK);
         total++;
         if (got_vec() !== V_LU) begin
            $display("FAIL lu_bubble%0d got=%b exp=%b",
                     i, got_vec(), V_LU);
            bad++;
         end
         tick();
         hz.load_ex = 1'b0;
      end
      @(negedge CLK);
      total++;
      if (got_vec() !== V_RUN || hz.stall_cycles !== 4'd2) begin
         $display("FAIL lu_after got=%b/%0d exp=%b/2",
                  got_vec(), hz.stall_cycles, V_RUN);
         bad++;
      end
      tick();
      hz.load_ex = 1'b1;
      hz.rd_ex   = '0;
      hz.rs_id   = '0;
      @(negedge CLK);
      total++;
      if (got_vec() !== V_RUN) begin
         $display("FAIL lu_r0 got=%b exp=%b", got_vec(), V_RUN);
         bad++;
      end
      tick();
      hz.rd_ex      = 5'd5;
      hz.rs_id      = 5'd3;
      hz.rt_id      = 5'd5;
      hz.uses_rt_id = 1'b0;
      @(negedge CLK);
      total++;
      if (got_vec() !== V_RUN) begin
         $display("FAIL lu_rt_unused got=%b exp=%b", got_vec(), V_RUN);
         bad++;
      end
      tick();
      hz.uses_rt_id = 1'b1;
      @(negedge CLK);
      total++;
      if (got_vec() !== V_LU) begin
         $display("FAIL lu_rt got=%b exp=%b", got_vec(), V_LU);
         bad++;
      end
      tick();
   endtask

   task automatic test_mem_wait();
      do_reset();
      hz.dmem_req_mem = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         total++;
         if (got_vec() !== V_OFF) begin
            $display("FAIL memwait%0d got=%b exp=%b",
                     i, got_vec(), V_OFF);
            bad++;
         end
         tick();
      end
      hz.dhit = 1'b1;
      @(negedge CLK);
      total++;
      if (got_vec() !== V_RUN || hz.stall_cycles !== 4'd3) begin
         $display("FAIL memwait_dhit got=%b/%0d exp=%b/3",
                  got_vec(), hz.stall_cycles, V_RUN);
         bad++;
      end
      tick();
      hz.ihit = 1'b0;
      @(negedge CLK);
      total++;
      if (got_vec() !== V_RET) begin
         $display("FAIL noihit_dhit got=%b exp=%b", got_vec(), V_RET);
         bad++;
      end
      tick();
      hz.dhit = 1'b0;
      hz.dmem_req_mem = 1'b0;
      @(negedge CLK);
      total++;
      if (got_vec() !== V_OFF) begin
         $display("FAIL noihit_idle got=%b exp=%b", got_vec(), V_OFF);
         bad++;
      end
      tick();
   endtask

   task automatic test_branch();
      do_reset();
      hz.br_taken_mem = 1'b1;
      hz.load_ex      = 1'b1;
      hz.rd_ex        = 5'd4;
      hz.rs_id        = 5'd4;
      @(negedge CLK);
      total++;
      if (got_vec() !== V_BR) begin
         $display("FAIL br_lu got=%b exp=%b", got_vec(), V_BR);
         bad++;
      end
      tick();
      hz.br_taken_mem = 1'b0;
      hz.load_ex      = 1'b0;
      @(negedge CLK);
      total++;
      if (got_vec() !== V_RUN) begin
         $display("FAIL br_nobubble got=%b exp=%b", got_vec(), V_RUN);
         bad++;
      end
      hz.load_ex = 1'b1;
      tick();
      hz.load_ex      = 1'b0;
      hz.br_taken_mem = 1'b1;
      @(negedge CLK);
      total++;
      if (got_vec() !== V_BR) begin
         $display("FAIL br_in_bubble got=%b exp=%b", got_vec(), V_BR);
         bad++;
      end
      tick();
      hz.br_taken_mem = 1'b0;
      @(negedge CLK);
      total++;
      if (got_vec() !== V_RUN) begin
         $display("FAIL br_to_run got=%b exp=%b", got_vec(), V_RUN);
         bad++;
      end
      tick();
   endtask

   task automatic test_jump();
      do_reset();
      hz.jump_id = 1'b1;
      @(negedge CLK);
      total++;
      if (got_vec() !== V_JMP) begin
         $display("FAIL jump got=%b exp=%b", got_vec(), V_JMP);
         bad++;
      end
      tick();
      hz.load_ex = 1'b1;
      hz.rd_ex   = 5'd9;
      hz.rt_id   = 5'd9;
      hz.uses_rt_id = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge CLK);
         total++;
         if (got_vec() !== V_LU) begin
            $display("FAIL jump_lu%0d got=%b exp=%b",
                     i, got_vec(), V_LU);
            bad++;
         end
         tick();
         hz.load_ex = 1'b0;
      end
      @(negedge CLK);
      total++;
      if (got_vec() !== V_JMP) begin
         $display("FAIL jump_retry got=%b exp=%b", got_vec(), V_JMP);
         bad++;
      end
      tick();
   endtask

   task automatic test_halt();
      logic [CW-1:0] s0;
      do_reset();
      hz.ihit = 1'b0;
      tick();
      hz.ihit    = 1'b1;
      hz.halt_wb = 1'b1;
      @(negedge CLK);
      total++;
      if (got_vec() !== V_RUN || hz.halted !== 1'b0) begin
         $display("FAIL halt_cycle got=%b/%b exp=%b/0",
                  got_vec(), hz.halted, V_RUN);
         bad++;
      end
      tick();
      hz.halt_wb = 1'b0;
      @(negedge CLK);
      total++;
      if (got_vec() !== V_OFF || hz.halted !== 1'b1) begin
         $display("FAIL halted got=%b/%b exp=%b/1",
                  got_vec(), hz.halted, V_OFF);
         bad++;
      end
      s0 = CW'(m_stall);
      for (int i = 0; i < 3; i++) tick();
      @(negedge CLK);
      total++;
      if (hz.stall_cycles !== s0 || hz.halted !== 1'b1) begin
         $display("FAIL halt_frozen got=%0d/%b exp=%0d/1",
                  hz.stall_cycles, hz.halted, s0);
         bad++;
      end
   endtask

   task automatic test_reset_mid_bubble();
      do_reset();
      hz.load_ex = 1'b1;
      hz.rd_ex   = 5'd2;
      hz.rs_id   = 5'd2;
      tick();
      hz.load_ex = 1'b0;
      #2;
      nRST = 1'b0;
      #1;
      total++;
      if (got_vec() !== V_OFF || hz.halted !== 1'b0 ||
          hz.stall_cycles !== '0) begin
         $display("FAIL rst_mid got=%b/%b/%0d exp=%b/0/0",
                  got_vec(), hz.halted, hz.stall_cycles, V_OFF);
         bad++;
      end
      model_reset();
      @(negedge CLK);
      nRST = 1'b1;
      @(posedge CLK);
      #1;
      @(negedge CLK);
      total++;
      if (got_vec() !== V_RUN) begin
         $display("FAIL rst_mid_run got=%b exp=%b", got_vec(), V_RUN);
         bad++;
      end
      tick();
   endtask

   task automatic test_saturate();
      do_reset();
      hz.dmem_req_mem = 1'b1;
      for (int i = 0; i < MAXC + 5; i++) tick();
      @(negedge CLK);
      total++;
      if (hz.stall_cycles !== CW'(MAXC)) begin
         $display("FAIL stall_sat got=%0d exp=%0d",
                  hz.stall_cycles, MAXC);
         bad++;
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 600; i++) begin
         nRST            = ($urandom_range(0, 39) != 0);
         hz.ihit         = ($urandom_range(0, 4) != 0);
         hz.dhit         = $urandom_range(0, 1) == 1;
         hz.dmem_req_mem = $urandom_range(0, 2) == 0;
         hz.load_ex      = $urandom_range(0, 1) == 1;
         hz.rd_ex        = RW'($urandom_range(0, 3));
         hz.rs_id        = RW'($urandom_range(0, 3));
         hz.rt_id        = RW'($urandom_range(0, 3));
         hz.uses_rt_id   = $urandom_range(0, 1) == 1;
         hz.jump_id      = $urandom_range(0, 3) == 0;
         hz.br_taken_mem = $urandom_range(0, 5) == 0;
         hz.halt_wb      = $urandom_range(0, 59) == 0;
         if (!nRST) model_reset();
         @(negedge CLK);
         total++;
         if (got_vec() !== model_out() ||
             hz.halted !== m_halt ||
             hz.stall_cycles !== CW'(m_stall)) begin
            $display("FAIL rand%0d got=%b/%b/%0d exp=%b/%b/%0d",
                     i, got_vec(), hz.halted, hz.stall_cycles,
                     model_out(), m_halt, m_stall);
            bad++;
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_run();
      test_load_use();
      test_mem_wait();
      test_branch();
      test_jump();
      test_halt();
      test_reset_mid_bubble();
      test_saturate();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/hazard_ctrl_param.md
Name: hazard_ctrl_param

Overview:
Parametrised pipeline hazard controller for the 5-stage MIPS datapath; generational successor to the basic hit-gated enable/flush unit. It drives enable/flush for the IF_ID, ID_EX, EX_MEM and MEM_WB latches, plus PC enable. It adds load-use bubble insertion with configurable depth, branch/jump flushing, dmem wait stalls, a sticky halt, and a saturating stall-cycle counter.

Parameters:
REG_W, 5, register address width.
LU_BUBBLES, 1, bubbles inserted per load-use hazard; legal 1..3.
CNT_W, 32, stall-cycle counter width.

Ports:
CLK  in  1  clock, rising edge.
nRST  in  1  asynchronous active-low reset.
ihit  in  1  instruction fetch complete this cycle.
dhit  in  1  data access complete this cycle.
dmem_req_mem  in  1  MEM-stage instruction is a load or store.
load_ex  in  1  EX-stage instruction is a load.
rd_ex  in  REG_W  EX-stage destination register.
rs_id  in  REG_W  ID-stage source rs.
rt_id  in  REG_W  ID-stage source rt.
uses_rt_id  in  1  ID instruction reads rt.
jump_id  in  1  jump resolved in ID.
br_taken_mem  in  1  taken branch resolved in MEM.
halt_wb  in  1  HALT in WB.
enable_IF_ID, enable_ID_EX, enable_EX_MEM, enable_MEM_WB  out  1 each  latch enables.
flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB  out  1 each  synchronous latch clears (effective only with matching enable).
pc_en  out  1  PC update enable.
halted  out  1  sticky halt flag.
stall_cycles  out  CNT_W  saturating count of cycles with pc_en=0 while not halted.

Behaviour:
- Reset: state RUN, bubble counter 0, halted 0, stall_cycles 0. While nRST=0, every enable, flush and pc_en is 0.
- Definitions: mem_wait = dmem_req_mem & ~dhit; adv = ihit & ~mem_wait.
- lu_haz = load_ex & (rd_ex != 0) & ((rd_ex == rs_id) | (uses_rt_id & (rd_ex == rt_id))).
- Register 0 never causes a hazard.
- State RUN, mem_wait=1: all enables 0 and pc_en 0. The whole pipeline freezes until dhit.
- State RUN, adv=0 (ihit low, no mem_wait): IF_ID and ID_EX enables 0. EX_MEM and MEM_WB enable = dhit, and flush_EX_MEM = dhit, so the completed memory op retires and no duplicate access occurs.
- State RUN, adv=1, priority br_taken_mem > lu_haz > jump_id:
  - br_taken_mem: all enables 1, pc_en 1; flush IF_ID, ID_EX, EX_MEM. Any lu_haz is ignored because its load is squashed.
  - lu_haz: pc_en 0, enable_IF_ID 0, enable_ID_EX 1 with flush_ID_EX 1, EX_MEM and MEM_WB enabled. If LU_BUBBLES>1, go to BUBBLE with counter = LU_BUBBLES-1.
  - jump_id: all enables 1, pc_en 1, flush_IF_ID 1.
  - otherwise: all enables 1, no flushes, pc_en 1.
- State BUBBLE:
  - Same outputs as lu_haz whenever adv=1; the counter decrements on each adv cycle and the state returns to RUN when it reaches 0.
  - mem_wait freezes everything, counter held.
  - br_taken_mem with adv=1 overrides: branch outputs, return to RUN, counter cleared.
- halt_wb=1 on an adv cycle sets halted at the next edge. Once halted=1, all enables, flushes and pc_en are 0; only nRST clears it.
- stall_cycles increments on each cycle with halted=0 and pc_en=0, saturating at all-ones. It is held once halted.
- Simultaneous jump_id & lu_haz: load-use wins; the jump re-evaluates after the bubble(s).
- Reset asserted mid-BUBBLE or mid-wait: immediate return to the reset values above.
- Outputs are combinational from state and inputs; no added latency.

Test Plan:
1. Reset, then ihit=1, dhit=0, no requests -> all enables 1, pc_en 1, flushes 0, stall_cycles 0.
2. load_ex=1, rd_ex=8, rs_id=8, ihit=1, LU_BUBBLES=2 -> two consecutive cycles of pc_en=0, enable_IF_ID=0, flush_ID_EX=1, then RUN; stall_cycles=2. Repeat with rd_ex=0 -> no stall.
3. dmem_req_mem=1, dhit=0 for 3 cycles then dhit=1 -> all enables 0 for 3 cycles; on the dhit cycle EX_MEM and MEM_WB enabled; stall_cycles=3.
4. br_taken_mem=1 with lu_haz=1 in the same cycle -> flush IF_ID, ID_EX, EX_MEM asserted, pc_en 1, no bubble. Also br_taken_mem during BUBBLE (count 1 remaining) -> RUN next cycle.
5. jump_id=1, ihit=1 -> flush_IF_ID=1 only. With lu_haz also 1 -> load-use outputs, flush_IF_ID=0.
6. halt_wb=1 with adv -> halted=1 next cycle, all outputs 0, counter frozen. Drop nRST mid-BUBBLE -> outputs 0 immediately, halted 0, counter 0.
